// File: rtl/textmode_scanner.sv
// Text-mode raster scanner: walks a 800x525 pixel raster, addresses an 80x30 cell
// display memory and hands cell data, glyph position, blanking and sync to a character generator.
module textmode_scanner #(
    parameter int BLINK_LOG2   = 5,
    parameter int H_TOTAL      = 800,
    parameter int H_VISIBLE    = 640,
    parameter int HSYNC_START  = 656,
    parameter int HSYNC_END    = 751,
    parameter int V_TOTAL      = 525,
    parameter int V_VISIBLE    = 480,
    parameter int VSYNC_START  = 490,
    parameter int VSYNC_END    = 491
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pixclk,
    output logic [11:0] mem_addr,
    output logic        mem_en,
    input  logic [15:0] mem_data,
    output logic [7:0]  chrcode,
    output logic [7:0]  attcode,
    output logic [3:0]  chrrow,
    output logic [2:0]  chrcol,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        blink
);

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_FIRST = 10'(HSYNC_START);
    localparam logic [9:0]  HS_LAST  = 10'(HSYNC_END);
    localparam logic [9:0]  VS_FIRST = 10'(VSYNC_START);
    localparam logic [9:0]  VS_LAST  = 10'(VSYNC_END);
    localparam logic [11:0] COLS     = 12'(H_VISIBLE / 8);
    localparam int          FW       = BLINK_LOG2 + 1;

    logic [9:0]    hcnt_r;
    logic [9:0]    vcnt_r;
    logic [FW-1:0] frame_r;

    logic          line_end_s;
    logic          frame_end_s;
    logic          visible_s;
    logic          blank0_s;
    logic          hsync0_s;
    logic          vsync0_s;
    logic [11:0]   addr_s;

    logic          blank_r;
    logic          hsync_r;
    logic          vsync_r;
    logic [3:0]    chrrow_r;
    logic [2:0]    chrcol_r;
    logic          blink_r;

    assign line_end_s  = (hcnt_r == H_LAST);
    assign frame_end_s = line_end_s && (vcnt_r == V_LAST);
    assign visible_s   = (hcnt_r < H_VIS) && (vcnt_r < V_VIS);

    // Stage-0 timing and cell address derived from the current raster position
    always_comb begin
        blank0_s = 1'b1;
        hsync0_s = 1'b1;
        vsync0_s = 1'b1;
        addr_s   = 12'd0;
        if (visible_s) begin
            blank0_s = 1'b0;
            addr_s   = ({7'd0, vcnt_r[8:4]} * COLS) + {5'd0, hcnt_r[9:3]};
        end else begin
            blank0_s = 1'b1;
            addr_s   = 12'd0;
        end
        if ((hcnt_r >= HS_FIRST) && (hcnt_r <= HS_LAST)) begin
            hsync0_s = 1'b0;
        end else begin
            hsync0_s = 1'b1;
        end
        if ((vcnt_r >= VS_FIRST) && (vcnt_r <= VS_LAST)) begin
            vsync0_s = 1'b0;
        end else begin
            vsync0_s = 1'b1;
        end
    end

    // Raster position and frame counter; line and frame wrap share the last step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_r  <= 10'd0;
            vcnt_r  <= 10'd0;
            frame_r <= '0;
        end else if (pixclk) begin
            if (line_end_s) begin
                hcnt_r <= 10'd0;
                if (frame_end_s) begin
                    vcnt_r  <= 10'd0;
                    frame_r <= frame_r + {{(FW-1){1'b0}}, 1'b1};
                end else begin
                    vcnt_r <= vcnt_r + 10'd1;
                end
            end else begin
                hcnt_r <= hcnt_r + 10'd1;
            end
        end
    end

    // Outputs delayed one step so they line up with mem_data for the same cell
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_r  <= 1'b1;
            hsync_r  <= 1'b1;
            vsync_r  <= 1'b1;
            chrrow_r <= 4'd0;
            chrcol_r <= 3'd0;
            blink_r  <= 1'b0;
        end else if (pixclk) begin
            blank_r  <= blank0_s;
            hsync_r  <= hsync0_s;
            vsync_r  <= vsync0_s;
            chrrow_r <= vcnt_r[3:0];
            chrcol_r <= hcnt_r[2:0];
            blink_r  <= frame_r[FW-1];
        end
    end

    assign mem_addr = addr_s;
    assign mem_en   = pixclk;
    assign chrcode  = mem_data[7:0];
    assign attcode  = mem_data[15:8];
    assign chrrow   = chrrow_r;
    assign chrcol   = chrcol_r;
    assign blank    = blank_r;
    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign blink    = blink_r;

endmodule

// File: tb/tb_textmode_scanner.sv
// Directed bench: instance a uses full raster timing, instance b a narrow 16-pixel line
// so full frames (vsync, blink) fit in a short run.
module tb_textmode_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pix_a = 1'b0;
    logic        pix_b = 1'b0;
    logic [15:0] mem_data = 16'd0;

    logic [11:0] addr_a, addr_b;
    logic        en_a, en_b;
    logic [7:0]  chr_a, chr_b, att_a, att_b;
    logic [3:0]  row_a, row_b;
    logic [2:0]  col_a, col_b;
    logic        blank_a, blank_b, hs_a, hs_b, vs_a, vs_b, blink_a, blink_b;

    int checks = 0;
    int errors = 0;
    int cnt;

    always #5 clk = ~clk;

    textmode_scanner dut_a (
        .clk(clk), .reset_n(reset_n), .pixclk(pix_a), .mem_addr(addr_a), .mem_en(en_a),
        .mem_data(mem_data), .chrcode(chr_a), .attcode(att_a), .chrrow(row_a), .chrcol(col_a),
        .blank(blank_a), .hsync(hs_a), .vsync(vs_a), .blink(blink_a)
    );

    textmode_scanner #(
        .BLINK_LOG2(1), .H_TOTAL(16), .H_VISIBLE(8), .HSYNC_START(10), .HSYNC_END(12)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pixclk(pix_b), .mem_addr(addr_b), .mem_en(en_b),
        .mem_data(mem_data), .chrcode(chr_b), .attcode(att_b), .chrrow(row_b), .chrcol(col_b),
        .blank(blank_b), .hsync(hs_b), .vsync(vs_b), .blink(blink_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with clock running
        #2 reset_n = 1'b0;
        pix_a = 1'b1;
        step(3);
        chk("rst_blank", 16'(blank_a), 16'd1);
        chk("rst_hsync", 16'(hs_a), 16'd1);
        chk("rst_vsync", 16'(vs_a), 16'd1);
        chk("rst_row", 16'(row_a), 16'd0);
        chk("rst_col", 16'(col_a), 16'd0);
        chk("rst_blink", 16'(blink_a), 16'd0);
        chk("rst_addr", 16'(addr_a), 16'd0);
        chk("mem_en_hi", 16'(en_a), 16'd1);
        reset_n = 1'b1;
        chk("addr_step0", 16'(addr_a), 16'd0);

        step(1);
        chk("first_blank", 16'(blank_a), 16'd0);
        chk("first_row", 16'(row_a), 16'd0);
        chk("first_col", 16'(col_a), 16'd0);
        step(7);
        chk("addr_step8", 16'(addr_a), 16'd1);
        chk("col_step8", 16'(col_a), 16'd7);
        step(631);
        chk("addr_h639", 16'(addr_a), 16'd79);
        step(1);
        chk("addr_h640", 16'(addr_a), 16'd0);
        chk("blank_e640", 16'(blank_a), 16'd0);
        step(1);
        chk("blank_e641", 16'(blank_a), 16'd1);
        step(15);
        chk("hsync_e656", 16'(hs_a), 16'd1);
        step(1);
        chk("hsync_e657", 16'(hs_a), 16'd0);
        cnt = 0;
        while (hs_a === 1'b0 && cnt < 200) begin
            cnt++;
            step(1);
        end
        chk("hsync_width", 16'(cnt), 16'd96);

        step(47);
        chk("blank_e800", 16'(blank_a), 16'd1);
        chk("addr_line1", 16'(addr_a), 16'd0);
        step(1);
        chk("line1_blank", 16'(blank_a), 16'd0);
        chk("line1_row", 16'(row_a), 16'd1);
        chk("line1_col", 16'(col_a), 16'd0);

        // last cell column of glyph row 15
        step(11838);
        chk("addr_v15h639", 16'(addr_a), 16'd79);
        mem_data = 16'hA541;
        #1;
        chk("chrcode", 16'(chr_a), 16'h0041);
        chk("attcode", 16'(att_a), 16'h00A5);
        step(1);
        chk("row15", 16'(row_a), 16'd15);
        chk("col7", 16'(col_a), 16'd7);
        chk("blank_v15h639", 16'(blank_a), 16'd0);
        step(168);
        chk("addr_v16h8", 16'(addr_a), 16'd81);
        chk("row_v16", 16'(row_a), 16'd0);

        // pixel enable stalls and half-rate stepping
        pix_a = 1'b0;
        step(3);
        chk("stall_addr", 16'(addr_a), 16'd81);
        chk("stall_col", 16'(col_a), 16'd7);
        chk("mem_en_lo", 16'(en_a), 16'd0);
        for (int i = 0; i < 14; i++) begin
            pix_a = (i % 2 == 0);
            step(1);
        end
        chk("half_addr", 16'(addr_a), 16'd81);
        chk("half_col", 16'(col_a), 16'd6);
        pix_a = 1'b1;
        step(1);
        chk("half_addr2", 16'(addr_a), 16'd82);
        chk("half_col2", 16'(col_a), 16'd7);

        // reset in the middle of an hsync pulse
        step(684);
        chk("hsync_mid", 16'(hs_a), 16'd0);
        chk("col_mid", 16'(col_a), 16'd3);
        reset_n = 1'b0;
        #1;
        chk("midrst_hsync", 16'(hs_a), 16'd1);
        chk("midrst_blank", 16'(blank_a), 16'd1);
        chk("midrst_col", 16'(col_a), 16'd0);
        chk("midrst_addr", 16'(addr_a), 16'd0);

        // narrow-line instance: vsync, frame wrap, blink
        pix_a = 1'b0;
        pix_b = 1'b1;
        step(2);
        reset_n = 1'b1;
        chk("b_addr0", 16'(addr_b), 16'd0);
        step(4200);
        chk("b_blink_f0", 16'(blink_b), 16'd0);
        step(3640);
        chk("b_vsync_e7840", 16'(vs_b), 16'd1);
        step(1);
        chk("b_vsync_e7841", 16'(vs_b), 16'd0);
        cnt = 0;
        while (vs_b === 1'b0 && cnt < 100) begin
            cnt++;
            step(1);
        end
        chk("b_vsync_width", 16'(cnt), 16'd32);
        step(527);
        chk("b_row_v524", 16'(row_b), 16'd12);
        chk("b_blank_end", 16'(blank_b), 16'd1);
        chk("b_addr_wrap", 16'(addr_b), 16'd0);
        step(1);
        chk("b_blank_f1", 16'(blank_b), 16'd0);
        chk("b_row_f1", 16'(row_b), 16'd0);
        chk("b_col_f1", 16'(col_b), 16'd0);
        step(4199);
        chk("b_blink_f1", 16'(blink_b), 16'd0);
        step(8400);
        chk("b_blink_f2", 16'(blink_b), 16'd1);
        step(8400);
        chk("b_blink_f3", 16'(blink_b), 16'd1);
        reset_n = 1'b0;
        #1;
        chk("b_rst_blink", 16'(blink_b), 16'd0);
        chk("b_rst_vsync", 16'(vs_b), 16'd1);
        chk("b_rst_hsync", 16'(hs_b), 16'd1);
        chk("b_rst_blank", 16'(blank_b), 16'd1);
        chk("b_rst_row", 16'(row_b), 16'd0);
        chk("b_mem_en", 16'(en_b), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/textmode_scanner.md
TEXTMODE_SCANNER -- requirements
Module: textmode_scanner

Interface
REQ-001 SHALL have parameter BLINK_LOG2, default 5, giving blink half-period as 2^BLINK_LOG2 frames.
REQ-002 SHALL have port clk, input, 1: system clock.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port pixclk, input, 1: pixel enable; all state advances only on clk rising edges with pixclk=1.
REQ-005 SHALL have port mem_addr, output, 12: display-memory cell address.
REQ-006 SHALL have port mem_en, output, 1: display-memory read enable.
REQ-007 SHALL have port mem_data, input, 16: cell data, [7:0] character code, [15:8] attribute; valid one pixclk step after mem_addr.
REQ-008 SHALL have ports chrcode (output, 8) and attcode (output, 8): character code and attribute for the character generator.
REQ-009 SHALL have ports chrrow (output, 4) and chrcol (output, 3): glyph row and column for the character generator.
REQ-010 SHALL have ports blank, hsync and vsync (each output, 1): blanking and sync toward the character generator.
REQ-011 SHALL have port blink, output, 1: blink phase.

Function
REQ-012 SHALL keep hcnt (10 bit, 0..799) and vcnt (10 bit, 0..524); on each pixclk step hcnt increments; at 799 hcnt wraps to 0 and vcnt increments; at vcnt=524 with hcnt=799 both wrap to 0.
REQ-013 SHALL treat the visible window as hcnt<640 and vcnt<480, giving 80x30 cells of 8x16 pixels.
REQ-014 SHALL drive mem_addr = (vcnt[8:4])*80 + hcnt[9:3] when visible and 0 otherwise; 12-bit result, maximum 2399, no overflow.
REQ-015 SHALL drive mem_en = pixclk.
REQ-016 SHALL compute stage-0 timing combinationally: blank0 = not visible; hsync0 = 0 for hcnt in 656..751, else 1; vsync0 = 0 for vcnt in 490..491, else 1 (both active-low).
REQ-017 SHALL register blank0, hsync0, vsync0, vcnt[3:0] and hcnt[2:0] on each pixclk step into blank, hsync, vsync, chrrow and chrcol, so these outputs lag the address by exactly one pixclk step and align with mem_data.
REQ-018 SHALL pass chrcode = mem_data[7:0] and attcode = mem_data[15:8] combinationally.
REQ-019 SHALL keep a frame counter of BLINK_LOG2+1 bits that increments when vcnt and hcnt wrap to 0; blink = its MSB, registered alongside REQ-017.
REQ-020 SHALL hold all registers when pixclk=0; outputs stay stable between steps.
REQ-021 SHALL give end-to-end latency from counter position to the chrgen input of one pixclk step; the chrgen adds its own step.
REQ-022 SHALL apply a line wrap and a frame wrap in the same step at hcnt=799, vcnt=524 (frame counter increments once).

Reset
REQ-023 SHALL, while reset_n=0 and regardless of clk: hcnt=0, vcnt=0, frame counter=0, blank=1, hsync=1, vsync=1, chrrow=0, chrcol=0, blink=0.
REQ-024 SHALL start counting on the first pixclk step after reset_n rises, with the first step registering the position (0,0): blank=0, chrrow=0, chrcol=0.
REQ-025 SHALL, on reset mid-line or mid-frame, abort at once and restart at (0,0); no partial sync pulse is held.

Verification
REQ-026 Reset, then pixclk=1 every clk -> mem_addr=0 at step 0; at step 8 mem_addr=1; at step 640 blank=1 one step later.
REQ-027 Run to hcnt=656 -> hsync=0 registered one step later, for exactly 96 steps; run to vcnt=490 -> vsync=0 for exactly 2 lines (1600 steps).
REQ-028 Position hcnt=639, vcnt=479 -> mem_addr=2399; mem_data=16'hA541 -> chrcode=8'h41, attcode=8'hA5, chrrow=15, chrcol=7 after one step.
REQ-029 pixclk=1 on every 2nd clk -> counters, mem_addr and outputs advance only on pixclk cycles; one full frame = 420000 pixclk steps = 840000 clks.
REQ-030 With BLINK_LOG2=1, run 4 frames -> blink reads 0,0,1,1 per frame; assert reset_n=0 mid-frame -> all outputs take the REQ-023 values immediately.
